// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: control handshake, instruction-memory port and IR outputs.
// master = fetch unit, slave = control unit / memory side.
interface instr_fetch_unit_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 8
);
  logic               start;
  logic               fetch_req;
  logic               end_op;
  logic               jmp;
  logic [ADDR_W-1:0]  jmp_target;
  logic [ADDR_W-1:0]  im_addr;
  logic               im_rd_en;
  logic [INSTR_W-1:0] im_rdata;
  logic [INSTR_W-1:0] ir;
  logic               ir_valid;
  logic [ADDR_W-1:0]  pc;
  logic               halted;

  modport master (
    input  start, fetch_req, end_op,
    input  jmp, jmp_target, im_rdata,
    output im_addr, im_rd_en, ir,
    output ir_valid, pc, halted
  );

  modport slave (
    output start, fetch_req, end_op,
    output jmp, jmp_target, im_rdata,
    input  im_addr, im_rd_en, ir,
    input  ir_valid, pc, halted
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, sync instruction-memory read, IR hold until fetch_req.
// Define IFU_BRANCH_EN to honour jmp/jmp_target on fetch_req.
module instr_fetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int INSTR_W  = 8,
  parameter int RESET_PC = 0
) (
  input logic clk,
  input logic rst_n,
  instr_fetch_unit_if.master bus
);
  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

  typedef enum logic [2:0] {
    IDLE, FETCH, CAPTURE, READY, HALT
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               take_jmp;

`ifdef IFU_BRANCH_EN
  assign take_jmp = bus.jmp;
`else
  logic unused_jmp;
  assign take_jmp   = 1'b0;
  assign unused_jmp = ^{bus.jmp, bus.jmp_target};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RST_PC;
      addr_q  <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    unique case (state_q)
      IDLE, HALT: begin
        if (bus.start) begin
          state_d = FETCH;
          pc_d    = RST_PC;
          addr_d  = RST_PC;
        end
      end
      FETCH: state_d = CAPTURE;
      CAPTURE: begin
        // An end_op here still lands the word in ir
        ir_d    = bus.im_rdata;
        pc_d    = addr_q + ADDR_W'(1);
        state_d = READY;
      end
      READY: begin
        if (bus.fetch_req) begin
          state_d = FETCH;
          addr_d  = take_jmp ? bus.jmp_target : pc_q;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.end_op && state_q != IDLE && state_q != HALT) begin
      state_d = HALT;
      addr_d  = addr_q;
    end
  end

  assign bus.im_rd_en = (state_q == FETCH);
  assign bus.im_addr  = bus.im_rd_en ? addr_q : '0;
  assign bus.ir       = ir_q;
  assign bus.ir_valid = (state_q == READY);
  assign bus.pc       = pc_q;
  assign bus.halted   = (state_q == HALT);
endmodule
